sdram_port_responder: RTL and testbench
=======================================

# sdram_port_responder

Single-clock responder for the internal SDRAM port interface (acc/we/adr/dat/sel/ack) driven by the Wishbone-side port bridges. It sits where the SDRAM controller would, on the sdram_clk side. It serves single-word byte-masked writes and wrapping, critical-word-first read bursts of 2^buf_width words from an on-chip word array. It is used as the controller stand-in for simulation and FPGA bring-up, and as the reference model for port-level verification.

## Interface
- MAX_BUF_WIDTH, 4: largest supported burst exponent; larger buf_width_i values are clamped to this.
- MEM_AW, 10: word-address width of the backing array (2^MEM_AW x 32 bits).
- READ_LATENCY, 2: cycles from read acceptance to the first read beat; legal values are 1..15.

Ports:
- sdram_clk  in  1  clock for everything in the block.
- sdram_rst_n  in  1  synchronous, active-low reset.
- acc_i  in  1  access request, held until the final ack.
- we_i  in  1  1 = write, 0 = read; sampled at acceptance.
- adr_i  in  32  byte address; bits [1:0] ignored.
- dat_i  in  32  write data.
- sel_i  in  4  write byte enables; sel_i[n] enables bits [8n+7:8n].
- buf_width_i  in  4  read burst exponent; burst length is 1<<min(buf_width_i, MAX_BUF_WIDTH).
- stall_i  in  1  refresh/stall injection; holds off beats.
- ack_o  out  1  one beat or write complete.
- adr_o  out  32  byte address of the current read beat, {.., 2'b00}.
- dat_o  out  32  read data, valid while ack_o is high.

## Operation
- States: IDLE, WRITE, LAT, BURST, TURN.
- IDLE:
  - acc_i=1 with we_i=1 latches adr, dat and sel, then goes to WRITE.
  - acc_i=1 with we_i=0 latches the address and bw=min(buf_width_i, MAX_BUF_WIDTH), loads the latency counter with READ_LATENCY-1, and goes to LAT.
- WRITE: at the first edge with stall_i=0:
  - writes the selected bytes to mem[adr[MEM_AW+1:2]];
  - drives ack_o=1 for exactly one cycle;
  - goes to TURN.
- LAT: the counter decrements each cycle. At 0 it issues beat 0 (subject to stall_i) and goes to BURST.
- BURST:
  - Beat k address is {adr[31:bw+2], (adr[bw+1:2] + k) mod 2^bw, 2'b00}. Bits above bw+2 are constant, the start word is returned first, and the index wraps inside the aligned block.
  - Each edge with stall_i=0 emits the next beat. An edge with stall_i=1 emits nothing (ack_o=0) and holds k.
  - After beat 2^bw-1 the block goes to TURN.
- TURN: one cycle with no acceptance, then IDLE. A request is never accepted in the cycle following a final ack.
- Abort: acc_i=0 in LAT, BURST or WRITE (before the ack) returns to IDLE at the next edge. No further ack is issued and no write is performed.
- Memory index is adr[MEM_AW+1:2]; higher address bits alias. Memory is not reset.
- bw=0 gives a single-beat read.

## Timing
- Reset (sdram_rst_n=0 at an edge) forces state IDLE, ack_o=0, adr_o=0, dat_o=0, and clears the beat and latency counters. This applies mid-burst too: the next cycle has ack_o=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Write:
  - accepted at edge T;
  - ack_o=1 in cycle T+1 if stall_i=0 in cycle T (each stalled cycle adds one);
  - a read issued after TURN returns the new data.
- Read:
  - accepted at edge T;
  - beat 0 with ack_o=1 in cycle T+READ_LATENCY when there is no stall;
  - beats follow on consecutive cycles;
  - the last beat is in cycle T+READ_LATENCY+2^bw-1;
  - the next acceptance is no earlier than edge T+READ_LATENCY+2^bw+1.
- dat_o is read from the array through the synchronous RAM port and aligned with ack_o/adr_o. The extra pipeline stage is absorbed inside the LAT count.
- dat_o and adr_o hold their last values when ack_o=0.

## Test plan
- Reset: hold sdram_rst_n=0 for 3 cycles with acc_i=1 -> ack_o=0, adr_o=0, dat_o=0. After release, a 0x10 read starts a fresh burst.
- Byte write then read:
  - mem[0x40] holds 0x00000000;
  - write 0xAABBCCDD with sel=4'b0101 to 0x100 -> single ack one cycle after acceptance;
  - a 1-beat read (buf_width_i=0) of 0x100 -> dat_o=0x00BB00DD.
- Wrapping burst:
  - preload mem[i]=i;
  - read adr 0x1C with buf_width_i=3 -> adr_o sequence 0x1C,0x00,0x04,…,0x18 and dat_o sequence 7,0,1,…,6;
  - first ack at acceptance+2, 8 consecutive acks.
- Stall: during the same burst, stall_i=1 for 3 cycles after beat 2 -> 3 ack-free cycles, then beat 3 with adr_o=0x08 and no beat lost or repeated.
- Abort and clamp:
  - drop acc_i after beat 1 -> no further acks, and an immediate next request is accepted;
  - buf_width_i=7 with MAX_BUF_WIDTH=4 -> exactly 16 beats.
- Back-to-back: a write to 0x200 followed by a read of 0x200 with acc_i held continuously -> read accepted only after the TURN cycle and returns the written data.

Source files
------------

// File: rtl/sdram_port_responder.sv
// sdram_port_responder: SDRAM-port stand-in serving byte-masked writes and
// wrapping critical-word-first read bursts from an on-chip word array.
module sdram_port_responder #(
  parameter int MAX_BUF_WIDTH = 4,
  parameter int MEM_AW        = 10,
  parameter int READ_LATENCY  = 2
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic [3:0]  buf_width_i,
  input  logic        stall_i,
  output logic        ack_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o
);
  localparam int KW = (MAX_BUF_WIDTH < 1) ? 1 : MAX_BUF_WIDTH;
  typedef enum logic [2:0] {IDLE, WRITE, LAT, BURST, TURN} state_t;
  state_t          state_q, state_d;
  logic [31:0]     req_adr_q, req_adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [3:0]      sel_q, sel_d;
  logic [3:0]      bw_q, bw_d;
  logic [3:0]      lat_q, lat_d;
  logic [KW-1:0]   k_q, k_d;
  logic            ack_q, ack_d;
  logic [31:0]     out_adr_q, out_adr_d;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [2**MEM_AW];
  logic [29:0]     word, mask, beat_word;
  logic            last, issue, do_write;
  assign word      = req_adr_q[31:2];
  assign mask      = 30'((32'd1 << bw_q) - 32'd1);
  // Upper word bits stay fixed; only the low bw bits advance and wrap.
  assign beat_word = (word & ~mask) | ((word + 30'(k_q)) & mask);
  assign last      = (30'(k_q) == mask);
  assign issue     = sdram_rst_n && acc_i && !stall_i &&
                     (state_q == BURST || (state_q == LAT && lat_q == 4'd0));
  assign do_write  = sdram_rst_n && acc_i && !stall_i && state_q == WRITE;
  always_comb begin
    state_d   = state_q;
    req_adr_d = req_adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    bw_d      = bw_q;
    lat_d     = lat_q;
    k_d       = k_q;
    ack_d     = 1'b0;
    out_adr_d = out_adr_q;
    case (state_q)
      IDLE: if (acc_i) begin
        req_adr_d = adr_i;
        if (we_i) begin
          wdat_d  = dat_i;
          sel_d   = sel_i;
          state_d = WRITE;
        end else begin
          bw_d    = (buf_width_i > 4'(MAX_BUF_WIDTH)) ? 4'(MAX_BUF_WIDTH) : buf_width_i;
          lat_d   = 4'(READ_LATENCY - 1);
          k_d     = '0;
          state_d = LAT;
        end
      end
      WRITE: begin
        state_d = !acc_i ? IDLE : (stall_i ? WRITE : TURN);
        ack_d   = acc_i && !stall_i;
      end
      LAT: begin
        state_d = acc_i ? LAT : IDLE;
        lat_d   = (lat_q != 4'd0) ? lat_q - 4'd1 : lat_q;
      end
      BURST:   state_d = acc_i ? BURST : IDLE;
      default: state_d = IDLE;
    endcase
    // Beat 0 leaves LAT through the same path as later beats, so a
    // single-beat burst goes straight to TURN.
    if (issue) begin
      ack_d     = 1'b1;
      out_adr_d = {beat_word, 2'b00};
      k_d       = k_q + KW'(1);
      state_d   = last ? TURN : BURST;
    end
  end
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state_q   <= IDLE;
      req_adr_q <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      bw_q      <= '0;
      lat_q     <= '0;
      k_q       <= '0;
      ack_q     <= 1'b0;
      out_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      req_adr_q <= req_adr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      bw_q      <= bw_d;
      lat_q     <= lat_d;
      k_q       <= k_d;
      ack_q     <= ack_d;
      out_adr_q <= out_adr_d;
    end
  end
  always_ff @(posedge sdram_clk) begin
    if (do_write)
      for (int b = 0; b < 4; b++)
        if (sel_q[b]) mem[req_adr_q[MEM_AW+1:2]][8*b +: 8] <= wdat_q[8*b +: 8];
  end
  // Synchronous read port; its output register is dat_o itself.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) rdata_q <= '0;
    else if (issue) rdata_q <= mem[beat_word[MEM_AW-1:0]];
  end
  assign ack_o = ack_q;
  assign adr_o = out_adr_q;
  assign dat_o = rdata_q;
endmodule

// File: tb/tb_sdram_port_responder.sv
// tb_sdram_port_responder: table-driven transaction vectors plus directed
// reset, abort and back-to-back sequences against a small word-array model.
module tb_sdram_port_responder;
  logic        clk = 1'b0, rst_n = 1'b0, acc = 1'b0, we = 1'b0, stall = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0, bw = '0;
  logic        ack_o;
  logic [31:0] adr_o, dat_o;
  int          total = 0, bad = 0;
  logic [31:0] mm [1024];
  bit          mv [1024];

  sdram_port_responder dut (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .acc_i(acc), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .buf_width_i(bw), .stall_i(stall),
    .ack_o(ack_o), .adr_o(adr_o), .dat_o(dat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [31:0] a, d;
    logic [3:0]  s, b;
    int          nb;
    logic [31:0] d0;
    int          lat, ss, sl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int n = 0, got = 0, first = -1, last_n = 0;
    int bc, wrap, w, base, idx;
    logic [31:0] ga [16];
    logic [31:0] gd [16];
    acc = 1'b1; we = v.w; adr = v.a; dat = v.d; sel = v.s; bw = v.b; stall = 1'b0;
    while (got < v.nb && n < 80) begin
      @(negedge clk);
      n++;
      if (ack_o) begin
        if (first < 0) first = n;
        last_n = n;
        if (got < 16) begin ga[got] = adr_o; gd[got] = dat_o; end
        got++;
      end
      stall = (n >= v.ss && n < v.ss + v.sl);
    end
    acc = 1'b0; stall = 1'b0;
    chk("beats", 32'(got), 32'(v.nb));
    chk("latency", 32'(first - 1), 32'(v.lat));
    if (got == v.nb) begin
      if (v.w) begin
        idx = int'(v.a >> 2) % 1024;
        for (int b = 0; b < 4; b++) if (v.s[b]) mm[idx][8*b +: 8] = v.d[8*b +: 8];
        if (v.s == 4'hF) mv[idx] = 1'b1;
      end else begin
        bc   = (v.b > 4) ? 4 : int'(v.b);
        wrap = 1 << bc;
        w    = int'(v.a >> 2);
        base = (w / wrap) * wrap;
        chk("dat0", gd[0], v.d0);
        chk("span", 32'(last_n - first), 32'(v.nb - 1 + v.sl));
        for (int k = 0; k < v.nb; k++) begin
          idx = base + ((w - base + k) % wrap);
          chk($sformatf("beat%0d_adr", k), ga[k], 32'(idx) << 2);
          if (mv[idx % 1024]) chk($sformatf("beat%0d_dat", k), gd[k], mm[idx % 1024]);
        end
      end
    end
    repeat (2) begin
      @(negedge clk);
      chk("extra_ack", {31'd0, ack_o}, 32'd0);
    end
  endtask

  vec_t tv [10];

  initial begin
    int n, got;
    tv[0] = '{1'b1, 32'h100,  32'hAABBCCDD, 4'b0101, 4'd0, 1, 32'h0,        1, 0, 0};
    tv[1] = '{1'b0, 32'h100,  32'h0,        4'h0,    4'd0, 1, 32'h00BB00DD, 2, 0, 0};
    tv[2] = '{1'b0, 32'h1C,   32'h0,        4'h0,    4'd3, 8, 32'd7,        2, 0, 0};
    tv[3] = '{1'b0, 32'h1C,   32'h0,        4'h0,    4'd3, 8, 32'd7,        2, 5, 3};
    tv[4] = '{1'b0, 32'h3C,   32'h0,        4'h0,    4'd7, 16, 32'd15,      2, 0, 0};
    tv[5] = '{1'b0, 32'h34,   32'h0,        4'h0,    4'd2, 4, 32'd13,       2, 0, 0};
    tv[6] = '{1'b1, 32'h1008, 32'h12345678, 4'b1000, 4'd0, 1, 32'h0,        3, 1, 2};
    tv[7] = '{1'b0, 32'h08,   32'h0,        4'h0,    4'd1, 2, 32'h12000002, 2, 0, 0};
    tv[8] = '{1'b0, 32'h04,   32'h0,        4'h0,    4'd0, 1, 32'd1,        2, 0, 0};
    tv[9] = '{1'b0, 32'h100,  32'h0,        4'h0,    4'd0, 1, 32'h00BB00DD, 2, 0, 0};
    // reset held with a pending request
    rst_n = 1'b0; acc = 1'b1; we = 1'b0; adr = 32'h10; bw = 4'd0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", {31'd0, ack_o}, 32'd0);
      chk("rst_adr", adr_o, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
    end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < 10);
    chk("post_rst_lat", 32'(n - 1), 32'd2);
    chk("post_rst_adr", adr_o, 32'h10);
    acc = 1'b0;
    repeat (2) @(negedge clk);
    // preload mem[i]=i and clear word 0x40
    for (int i = 0; i < 16; i++) run('{1'b1, 32'(i * 4), 32'(i), 4'hF, 4'd0, 1, 32'h0, 1, 0, 0});
    run('{1'b1, 32'h100, 32'h0, 4'hF, 4'd0, 1, 32'h0, 1, 0, 0});
    for (int i = 0; i < 10; i++) run(tv[i]);
    // abort a burst after beat 1, then request again immediately
    acc = 1'b1; we = 1'b0; adr = 32'h1C; bw = 4'd3;
    got = 0; n = 0;
    while (got < 2 && n < 20) begin @(negedge clk); n++; if (ack_o) got++; end
    chk("abort_beats", 32'(got), 32'd2);
    acc = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", {31'd0, ack_o}, 32'd0);
    run(tv[9]);
    // abort a stalled write: memory must be untouched
    acc = 1'b1; we = 1'b1; adr = 32'h100; dat = 32'hFFFFFFFF; sel = 4'hF; stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wabort_ack0", {31'd0, ack_o}, 32'd0);
    acc = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("wabort_ack1", {31'd0, ack_o}, 32'd0);
    run(tv[9]);
    // write then read with acc held continuously across TURN
    acc = 1'b1; we = 1'b1; adr = 32'h200; dat = 32'hCAFEF00D; sel = 4'hF; bw = 4'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < 10);
    chk("b2b_wlat", 32'(n - 1), 32'd1);
    we = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < 20);
    chk("b2b_rd_gap", 32'(n), 32'd4);
    chk("b2b_rd_dat", dat_o, 32'hCAFEF00D);
    chk("b2b_rd_adr", adr_o, 32'h200);
    acc = 1'b0;
    repeat (2) @(negedge clk);
    // reset in the middle of a burst
    acc = 1'b1; we = 1'b0; adr = 32'h1C; bw = 4'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < 10);
    chk("mid_beat0_dat", dat_o, 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    chk("mid_rst_adr", adr_o, 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    rst_n = 1'b1; acc = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_idle", {31'd0, ack_o}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
